ex_mem_req: RTL and testbench

Execute-to-memory boundary stage: registers one executed instruction, issues its load/store on the data SRAM-like bus (req/addr_ok/data_ok), and presents the instruction with the returned raw read word to the memory stage. The stage generates byte enables, replicates store data and detects misalignment. It holds at most one instruction, with valid/ready handshakes on both sides.

---
 rtl/ex_mem_req.sv | 147 ++++++++++++++
 tb/tb_ex_mem_req.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_req.sv
// Execute-to-memory boundary stage: holds one executed instruction, runs its load/store
// on the data SRAM-like bus and hands the instruction plus raw read word to the memory stage.
`timescale 1ns/1ps
module ex_mem_req #(
    parameter bit ALLOW_UNALIGNED_HALF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        o_ex_ready,
    input  logic        i_mem_ready,
    output logic        ex_to_mem_valid,
    input  logic [1:0]  ex_mem_op,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_signal,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        ex_rf_we,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_inst,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        ex_to_mem_mem_signal,
    output logic [3:0]  ex_to_mem_mem_re,
    output logic [31:0] ex_to_mem_alu_res,
    output logic [4:0]  ex_to_mem_rf_waddr,
    output logic        ex_to_mem_rf_we,
    output logic [31:0] ex_to_mem_pc,
    output logic [31:0] ex_to_mem_inst,
    output logic [31:0] mem_rdata,
    output logic        ex_to_mem_ale
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic        bad_addr;
    logic        accept;
    logic [3:0]  enables;
    logic [31:0] store_word;

    // Byte-enable and alignment decode of the incoming access; size 11 never has a legal lane set.
    always_comb begin
        enables    = 4'b0000;
        misaligned = 1'b0;
        case (ex_mem_size)
            2'b00: enables = 4'b0001 << ex_alu_res[1:0];
            2'b01: begin
                case (ex_alu_res[1:0])
                    2'b00: enables = 4'b0011;
                    2'b10: enables = 4'b1100;
                    2'b01: begin
                        if (ALLOW_UNALIGNED_HALF) enables = 4'b0110;
                        else                      misaligned = 1'b1;
                    end
                    default: misaligned = 1'b1;
                endcase
            end
            2'b10: begin
                if (ex_alu_res[1:0] == 2'b00) enables = 4'b1111;
                else                          misaligned = 1'b1;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        case (ex_mem_size)
            2'b00:   store_word = {4{ex_store_data[7:0]}};
            2'b01:   store_word = {2{ex_store_data[15:0]}};
            default: store_word = ex_store_data;
        endcase
    end

    assign is_load         = (ex_mem_op == 2'b01);
    assign is_store        = (ex_mem_op == 2'b10);
    assign is_mem          = is_load | is_store;
    assign bad_addr        = is_mem & misaligned;
    assign o_ex_ready      = (state == IDLE) | ((state == DONE) & i_mem_ready);
    assign accept          = ex_valid & o_ex_ready;
    assign ex_to_mem_valid = (state == DONE);
    assign data_req        = (state == REQ);

    // Accept takes priority in IDLE and DONE, which gives back-to-back hand-off without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            data_wr              <= 1'b0;
            data_wstrb           <= 4'b0000;
            data_addr            <= 32'd0;
            data_wdata           <= 32'd0;
            ex_to_mem_mem_signal <= 1'b0;
            ex_to_mem_mem_re     <= 4'b0000;
            ex_to_mem_alu_res    <= 32'd0;
            ex_to_mem_rf_waddr   <= 5'd0;
            ex_to_mem_rf_we      <= 1'b0;
            ex_to_mem_pc         <= 32'd0;
            ex_to_mem_inst       <= 32'd0;
            mem_rdata            <= 32'd0;
            ex_to_mem_ale        <= 1'b0;
        end else if (accept) begin
            ex_to_mem_mem_signal <= ex_mem_signal;
            ex_to_mem_alu_res    <= ex_alu_res;
            ex_to_mem_rf_waddr   <= ex_rf_waddr;
            ex_to_mem_rf_we      <= ex_rf_we & ~bad_addr;
            ex_to_mem_pc         <= ex_pc;
            ex_to_mem_inst       <= ex_inst;
            ex_to_mem_ale        <= bad_addr;
            ex_to_mem_mem_re     <= (is_load & ~misaligned) ? enables : 4'b0000;
            data_wr              <= is_store;
            data_wstrb           <= (is_store & ~misaligned) ? enables : 4'b0000;
            data_addr            <= {ex_alu_res[31:2], 2'b00};
            data_wdata           <= store_word;
            mem_rdata            <= 32'd0;
            state                <= (is_mem & ~misaligned) ? REQ : DONE;
        end else begin
            case (state)
                REQ: begin
                    if (data_addr_ok) state <= RESP;
                end
                RESP: begin
                    // Only aligned loads carry nonzero read enables, so stores keep mem_rdata at 0.
                    if (data_data_ok) begin
                        if (|ex_to_mem_mem_re) mem_rdata <= data_rdata;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (i_mem_ready) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_req.sv
// Bench for ex_mem_req: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_ex_mem_req;

    localparam bit ALLOW = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, i_mem_ready, ex_mem_signal, ex_rf_we;
    logic [1:0]  ex_mem_op, ex_mem_size;
    logic [31:0] ex_alu_res, ex_store_data, ex_pc, ex_inst;
    logic [4:0]  ex_rf_waddr;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    logic        o_ex_ready, ex_to_mem_valid, data_req, data_wr;
    logic [3:0]  data_wstrb, ex_to_mem_mem_re;
    logic [31:0] data_addr, data_wdata, ex_to_mem_alu_res, ex_to_mem_pc, ex_to_mem_inst, mem_rdata;
    logic        ex_to_mem_mem_signal, ex_to_mem_rf_we, ex_to_mem_ale;
    logic [4:0]  ex_to_mem_rf_waddr;

    logic        d1_ready, d1_valid, d1_req, d1_wr, d1_signal, d1_rf_we, d1_ale;
    logic [3:0]  d1_wstrb, d1_mem_re;
    logic [31:0] d1_addr, d1_wdata, d1_alu_res, d1_pc, d1_inst, d1_rdata;
    logic [4:0]  d1_waddr;

    always #5 clk = ~clk;

    ex_mem_req #(.ALLOW_UNALIGNED_HALF(ALLOW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .o_ex_ready(o_ex_ready),
        .i_mem_ready(i_mem_ready), .ex_to_mem_valid(ex_to_mem_valid),
        .ex_mem_op(ex_mem_op), .ex_mem_size(ex_mem_size), .ex_mem_signal(ex_mem_signal),
        .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data), .ex_rf_waddr(ex_rf_waddr),
        .ex_rf_we(ex_rf_we), .ex_pc(ex_pc), .ex_inst(ex_inst),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .ex_to_mem_mem_signal(ex_to_mem_mem_signal),
        .ex_to_mem_mem_re(ex_to_mem_mem_re), .ex_to_mem_alu_res(ex_to_mem_alu_res),
        .ex_to_mem_rf_waddr(ex_to_mem_rf_waddr), .ex_to_mem_rf_we(ex_to_mem_rf_we),
        .ex_to_mem_pc(ex_to_mem_pc), .ex_to_mem_inst(ex_to_mem_inst),
        .mem_rdata(mem_rdata), .ex_to_mem_ale(ex_to_mem_ale)
    );

    // Second instance with unaligned halfwords allowed; only checked in one directed scenario.
    ex_mem_req #(.ALLOW_UNALIGNED_HALF(1'b1)) dut_half (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .o_ex_ready(d1_ready),
        .i_mem_ready(i_mem_ready), .ex_to_mem_valid(d1_valid),
        .ex_mem_op(ex_mem_op), .ex_mem_size(ex_mem_size), .ex_mem_signal(ex_mem_signal),
        .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data), .ex_rf_waddr(ex_rf_waddr),
        .ex_rf_we(ex_rf_we), .ex_pc(ex_pc), .ex_inst(ex_inst),
        .data_req(d1_req), .data_wr(d1_wr), .data_wstrb(d1_wstrb), .data_addr(d1_addr),
        .data_wdata(d1_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .ex_to_mem_mem_signal(d1_signal),
        .ex_to_mem_mem_re(d1_mem_re), .ex_to_mem_alu_res(d1_alu_res),
        .ex_to_mem_rf_waddr(d1_waddr), .ex_to_mem_rf_we(d1_rf_we),
        .ex_to_mem_pc(d1_pc), .ex_to_mem_inst(d1_inst),
        .mem_rdata(d1_rdata), .ex_to_mem_ale(d1_ale)
    );

    typedef struct {
        logic        sig, we, ale, bus, load, wr;
        logic [3:0]  re, wstrb;
        logic [4:0]  waddr;
        logic [31:0] alu, pc, inst, addr, wdata, rdata;
    } rec_t;

    int   vectors = 0;
    int   errors  = 0;
    bit   m_held, m_done, m_acc;
    rec_t m_cur;

    // Expected outcome of one instruction, straight from the access rules.
    function automatic rec_t predict(input logic [1:0] op, input logic [1:0] size, input logic sig,
                                     input logic [31:0] alu, input logic [31:0] sd,
                                     input logic [4:0] waddr, input logic we,
                                     input logic [31:0] pc, input logic [31:0] inst, input bit allow);
        rec_t r;
        logic [1:0] off;
        logic [3:0] en;
        bit legal, ld, st;
        off   = alu[1:0];
        ld    = (op == 2'd1);
        st    = (op == 2'd2);
        legal = 1'b0;
        en    = 4'b0000;
        if (size == 2'd0) begin
            legal = 1'b1; en = 4'b0001 << off;
        end else if (size == 2'd1 && (off == 2'd0 || off == 2'd2 || (off == 2'd1 && allow))) begin
            legal = 1'b1; en = 4'b0011 << off;
        end else if (size == 2'd2 && off == 2'd0) begin
            legal = 1'b1; en = 4'b1111;
        end
        r.load  = ld;
        r.bus   = (ld || st) && legal;
        r.ale   = (ld || st) && !legal;
        r.sig   = sig;
        r.alu   = alu;
        r.waddr = waddr;
        r.we    = we && !r.ale;
        r.pc    = pc;
        r.inst  = inst;
        r.re    = (ld && legal) ? en : 4'b0000;
        r.wr    = st;
        r.wstrb = (st && legal) ? en : 4'b0000;
        r.addr  = alu & 32'hFFFF_FFFC;
        if (size == 2'd0)      r.wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
        else if (size == 2'd1) r.wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
        else                   r.wdata = sd;
        r.rdata = 32'd0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sig,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] waddr,
                         input logic we, input logic [31:0] pc, input logic [31:0] inst);
        ex_valid = 1'b1; ex_mem_op = op; ex_mem_size = size; ex_mem_signal = sig;
        ex_alu_res = alu; ex_store_data = sd; ex_rf_waddr = waddr; ex_rf_we = we;
        ex_pc = pc; ex_inst = inst;
    endtask

    task automatic quiet();
        ex_valid = 1'b0; ex_mem_op = 2'd0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        i_mem_ready = 1'b1;
    endtask

    task automatic clearModel();
        m_held = 1'b0; m_done = 1'b0; m_acc = 1'b0;
    endtask

    // One clock: compare DUT against the model, then advance the model across the edge.
    task automatic applyStimulus();
        rec_t nrec;
        bit acc, pop, ahs, dhs, exp_ready, exp_valid, exp_req;
        #1;
        exp_ready = !m_held || (m_done && i_mem_ready);
        exp_valid = m_held && m_done;
        exp_req   = m_held && m_cur.bus && !m_acc;
        checkOutput("o_ex_ready", 32'(o_ex_ready), 32'(exp_ready));
        checkOutput("valid", 32'(ex_to_mem_valid), 32'(exp_valid));
        checkOutput("data_req", 32'(data_req), 32'(exp_req));
        if (exp_req) begin
            checkOutput("data_addr", data_addr, m_cur.addr);
            checkOutput("data_wr", 32'(data_wr), 32'(m_cur.wr));
            checkOutput("data_wstrb", 32'(data_wstrb), 32'(m_cur.wstrb));
            if (m_cur.wr) checkOutput("data_wdata", data_wdata, m_cur.wdata);
        end
        if (exp_valid) begin
            checkOutput("mem_signal", 32'(ex_to_mem_mem_signal), 32'(m_cur.sig));
            checkOutput("mem_re", 32'(ex_to_mem_mem_re), 32'(m_cur.re));
            checkOutput("alu_res", ex_to_mem_alu_res, m_cur.alu);
            checkOutput("rf_waddr", 32'(ex_to_mem_rf_waddr), 32'(m_cur.waddr));
            checkOutput("rf_we", 32'(ex_to_mem_rf_we), 32'(m_cur.we));
            checkOutput("pc", ex_to_mem_pc, m_cur.pc);
            checkOutput("inst", ex_to_mem_inst, m_cur.inst);
            checkOutput("mem_rdata", mem_rdata, m_cur.rdata);
            checkOutput("ale", 32'(ex_to_mem_ale), 32'(m_cur.ale));
        end
        acc = ex_valid && exp_ready && rst;
        pop = exp_valid && i_mem_ready;
        ahs = exp_req && data_addr_ok;
        dhs = m_held && m_cur.bus && m_acc && !m_done && data_data_ok;
        nrec = predict(ex_mem_op, ex_mem_size, ex_mem_signal, ex_alu_res, ex_store_data,
                       ex_rf_waddr, ex_rf_we, ex_pc, ex_inst, ALLOW);
        @(posedge clk);
        if (!rst) begin
            clearModel();
        end else if (acc) begin
            m_cur = nrec; m_held = 1'b1; m_done = !nrec.bus; m_acc = 1'b0;
        end else if (pop) begin
            m_held = 1'b0; m_done = 1'b0;
        end else begin
            if (ahs) m_acc = 1'b1;
            if (dhs) begin
                m_done = 1'b1;
                m_cur.rdata = m_cur.load ? data_rdata : 32'd0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        quiet();
        ex_mem_size = 2'd0; ex_mem_signal = 1'b0; ex_alu_res = 32'd0; ex_store_data = 32'd0;
        ex_rf_waddr = 5'd0; ex_rf_we = 1'b0; ex_pc = 32'd0; ex_inst = 32'd0; data_rdata = 32'd0;
        clearModel();
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst o_ex_ready", 32'(o_ex_ready), 32'd1);
        checkOutput("rst valid", 32'(ex_to_mem_valid), 32'd0);
        checkOutput("rst data_req", 32'(data_req), 32'd0);
        checkOutput("rst data_wr", 32'(data_wr), 32'd0);
        checkOutput("rst wstrb", 32'(data_wstrb), 32'd0);
        checkOutput("rst data_addr", data_addr, 32'd0);
        checkOutput("rst mem_re", 32'(ex_to_mem_mem_re), 32'd0);
        checkOutput("rst rf_we", 32'(ex_to_mem_rf_we), 32'd0);
        checkOutput("rst mem_rdata", mem_rdata, 32'd0);
        checkOutput("rst ale", 32'(ex_to_mem_ale), 32'd0);
        rst = 1'b1;

        $display("[TB] ALU instruction");
        issue(2'd0, 2'd0, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 32'h1C00_0000, 32'h0280_0C05);
        applyStimulus();
        quiet();
        checkOutput("alu valid", 32'(ex_to_mem_valid), 32'd1);
        checkOutput("alu alu_res", ex_to_mem_alu_res, 32'h0000_1234);
        checkOutput("alu mem_re", 32'(ex_to_mem_mem_re), 32'd0);
        checkOutput("alu rf_we", 32'(ex_to_mem_rf_we), 32'd1);
        checkOutput("alu waddr", 32'(ex_to_mem_rf_waddr), 32'd5);
        checkOutput("alu data_req", 32'(data_req), 32'd0);
        applyStimulus();

        $display("[TB] load byte");
        issue(2'd1, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 5'd7, 1'b1, 32'h1C00_0004, 32'h2800_0000);
        applyStimulus();
        quiet();
        checkOutput("lb data_req", 32'(data_req), 32'd1);
        checkOutput("lb data_addr", data_addr, 32'h0000_1000);
        checkOutput("lb data_wr", 32'(data_wr), 32'd0);
        checkOutput("lb wstrb", 32'(data_wstrb), 32'd0);
        applyStimulus();
        applyStimulus();
        data_addr_ok = 1'b1;
        applyStimulus();
        data_addr_ok = 1'b0;
        checkOutput("lb resp data_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h80FF_FFFF;
        applyStimulus();
        data_data_ok = 1'b0; i_mem_ready = 1'b0;
        checkOutput("lb valid", 32'(ex_to_mem_valid), 32'd1);
        checkOutput("lb mem_re", 32'(ex_to_mem_mem_re), 32'b1000);
        checkOutput("lb mem_rdata", mem_rdata, 32'h80FF_FFFF);
        i_mem_ready = 1'b1;
        applyStimulus();

        $display("[TB] store half");
        issue(2'd2, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 1'b0, 32'h1C00_0008, 32'h2940_0000);
        applyStimulus();
        quiet();
        checkOutput("sh data_wr", 32'(data_wr), 32'd1);
        checkOutput("sh wstrb", 32'(data_wstrb), 32'b1100);
        checkOutput("sh wdata", data_wdata, 32'hBEEF_BEEF);
        data_addr_ok = 1'b1;
        applyStimulus();
        data_addr_ok = 1'b0;
        applyStimulus();
        checkOutput("sh wait valid", 32'(ex_to_mem_valid), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        applyStimulus();
        data_data_ok = 1'b0;
        checkOutput("sh valid", 32'(ex_to_mem_valid), 32'd1);
        checkOutput("sh mem_re", 32'(ex_to_mem_mem_re), 32'd0);
        checkOutput("sh mem_rdata", mem_rdata, 32'd0);
        applyStimulus();

        $display("[TB] misaligned word and half");
        issue(2'd1, 2'd2, 1'b0, 32'h0000_3001, 32'd0, 5'd9, 1'b1, 32'h1C00_000C, 32'h2880_0000);
        applyStimulus();
        quiet();
        checkOutput("lw mis ale", 32'(ex_to_mem_ale), 32'd1);
        checkOutput("lw mis rf_we", 32'(ex_to_mem_rf_we), 32'd0);
        checkOutput("lw mis mem_re", 32'(ex_to_mem_mem_re), 32'd0);
        checkOutput("lw mis data_req", 32'(data_req), 32'd0);
        issue(2'd1, 2'd1, 1'b1, 32'h0000_3001, 32'd0, 5'd10, 1'b1, 32'h1C00_0010, 32'h2A40_0000);
        applyStimulus();
        quiet();
        checkOutput("lh mis ale", 32'(ex_to_mem_ale), 32'd1);
        checkOutput("lh mis data_req", 32'(data_req), 32'd0);
        checkOutput("lh allow data_req", 32'(d1_req), 32'd1);
        data_addr_ok = 1'b1;
        applyStimulus();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        applyStimulus();
        quiet();
        checkOutput("lh allow valid", 32'(d1_valid), 32'd1);
        checkOutput("lh allow mem_re", 32'(d1_mem_re), 32'b0110);
        checkOutput("lh allow ale", 32'(d1_ale), 32'd0);
        checkOutput("lh allow rdata", d1_rdata, 32'h1234_5678);
        applyStimulus();

        $display("[TB] backpressure and back-to-back");
        issue(2'd0, 2'd0, 1'b0, 32'hAAAA_0000, 32'd0, 5'd3, 1'b1, 32'h1C00_0014, 32'h0010_0000);
        i_mem_ready = 1'b0;
        applyStimulus();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp o_ex_ready", 32'(o_ex_ready), 32'd0);
            checkOutput("bp valid", 32'(ex_to_mem_valid), 32'd1);
            checkOutput("bp alu_res", ex_to_mem_alu_res, 32'hAAAA_0000);
            applyStimulus();
        end
        issue(2'd0, 2'd0, 1'b0, 32'hBBBB_0004, 32'd0, 5'd4, 1'b1, 32'h1C00_0018, 32'h0010_0001);
        i_mem_ready = 1'b1;
        #1;
        checkOutput("b2b o_ex_ready", 32'(o_ex_ready), 32'd1);
        applyStimulus();
        quiet();
        checkOutput("b2b valid", 32'(ex_to_mem_valid), 32'd1);
        checkOutput("b2b alu_res", ex_to_mem_alu_res, 32'hBBBB_0004);
        applyStimulus();

        $display("[TB] reset during response");
        issue(2'd1, 2'd2, 1'b0, 32'h0000_4000, 32'd0, 5'd11, 1'b1, 32'h1C00_001C, 32'h2880_0001);
        applyStimulus();
        quiet();
        data_addr_ok = 1'b1;
        applyStimulus();
        data_addr_ok = 1'b0;
        rst = 1'b0;
        clearModel();
        #1;
        checkOutput("arst valid", 32'(ex_to_mem_valid), 32'd0);
        checkOutput("arst data_req", 32'(data_req), 32'd0);
        checkOutput("arst o_ex_ready", 32'(o_ex_ready), 32'd1);
        applyStimulus();
        rst = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        applyStimulus();
        data_data_ok = 1'b0;
        checkOutput("late data_ok valid", 32'(ex_to_mem_valid), 32'd0);
        checkOutput("late data_ok rdata", mem_rdata, 32'd0);
        applyStimulus();

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            ex_valid      = ($urandom % 3) != 0;
            ex_mem_op     = 2'($urandom_range(0, 2));
            ex_mem_size   = 2'($urandom_range(0, 3));
            ex_mem_signal = 1'($urandom % 2);
            ex_alu_res    = $urandom;
            ex_store_data = $urandom;
            ex_rf_waddr   = 5'($urandom % 32);
            ex_rf_we      = 1'($urandom % 2);
            ex_pc         = $urandom;
            ex_inst       = $urandom;
            i_mem_ready   = ($urandom % 4) != 0;
            data_addr_ok  = 1'($urandom % 2);
            data_rdata    = $urandom;
            if (m_held && m_cur.bus && m_acc && !m_done) data_data_ok = ($urandom % 3) == 0;
            else                                          data_data_ok = ($urandom % 4) == 0;
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
